// File: rtl/m26_tx_core.sv
// Mimosa26 stream transmitter: buffers hit words in a FIFO and serializes them as
// framed MKD + two-lane data, one bit per clock, MSB first.
module m26_tx_core #(
    parameter int unsigned FRAME_LEN = 576,
    parameter int unsigned FIFO_AW   = 9
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        ENABLE,
    input  logic        HIT_WR,
    input  logic [15:0] HIT_DATA,
    output logic        FULL,
    output logic [7:0]  LOST_CNT,
    output logic [31:0] FRAME_CNT,
    output logic        BUSY,
    output logic        FRAME_START,
    output logic        MKD_TX,
    output logic [1:0]  DATA_TX
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned WW    = $clog2(FRAME_LEN);
    localparam int unsigned L_CAP = ((FRAME_LEN - 5) < (DEPTH / 2)) ? (FRAME_LEN - 5) : (DEPTH / 2);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      rem;
    logic [CW-1:0]      len;
    logic [CW-1:0]      len_c;
    logic [CW-1:0]      rem_c;
    logic [WW-1:0]      word_idx;
    logic [3:0]         bit_idx;
    logic [31:0]        frame_num;
    logic [15:0]        sh0;
    logic [15:0]        sh1;
    logic [15:0]        word0;
    logic [15:0]        word1;
    logic               data_word;
    logic               pop0;
    logic               pop1;
    logic               wr_ok;
    logic [1:0]         pop_n;
    int unsigned        snap_n;
    int unsigned        snap_half;
    int unsigned        snap_l;
    int unsigned        wi;
    int unsigned        li;

    assign FULL = (count == CW'(DEPTH));

    // Frame length and pop budget for a snapshot of the current occupancy.
    always_comb begin
        snap_n    = 32'(count);
        snap_half = (snap_n + 1) / 2;
        snap_l    = (snap_half < L_CAP) ? snap_half : L_CAP;
        len_c     = CW'(snap_l);
        rem_c     = CW'(((2 * snap_l) < snap_n) ? (2 * snap_l) : snap_n);
    end

    // Word content for the current position; data words pop on their first bit.
    always_comb begin
        wi        = 32'(word_idx);
        li        = 32'(len);
        data_word = (state == SEND) && (bit_idx == 4'd0) && (wi >= 4) && (wi < li + 4);
        pop0      = data_word;
        pop1      = data_word && (rem >= CW'(2));
        pop_n     = {1'b0, pop0} + {1'b0, pop1};
        wr_ok     = HIT_WR && (!FULL || pop0);
        word0     = 16'h0000;
        word1     = 16'h0000;
        if (wi == 0) begin
            word0 = 16'h5555;
            word1 = 16'h5555;
        end else if (wi == 1) begin
            word0 = FRAME_CNT[31:16];
            word1 = FRAME_CNT[15:0];
        end else if (wi <= 3) begin
            word0 = 16'(len);
            word1 = 16'(len);
        end else if (wi < li + 4) begin
            word0 = mem[rd_ptr];
            word1 = (rem >= CW'(2)) ? mem[rd_ptr + FIFO_AW'(1)] : 16'h0000;
        end else if (wi == li + 4) begin
            word0 = 16'hAA50;
            word1 = 16'hAA50;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (wr_ok) mem[wr_ptr] <= HIT_DATA;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rem         <= '0;
            len         <= '0;
            word_idx    <= '0;
            bit_idx     <= '0;
            frame_num   <= '0;
            sh0         <= '0;
            sh1         <= '0;
            LOST_CNT    <= '0;
            FRAME_CNT   <= '0;
            BUSY        <= 1'b0;
            FRAME_START <= 1'b0;
            MKD_TX      <= 1'b0;
            DATA_TX     <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            rd_ptr <= rd_ptr + FIFO_AW'(pop_n);
            count  <= count + CW'(wr_ok) - CW'(pop_n);
            rem    <= rem - CW'(pop_n);
            if (HIT_WR && !wr_ok && (LOST_CNT != 8'hFF)) LOST_CNT <= LOST_CNT + 8'd1;

            if (state == IDLE) begin
                BUSY        <= 1'b0;
                FRAME_START <= 1'b0;
                MKD_TX      <= 1'b0;
                DATA_TX     <= '0;
                if (ENABLE) begin
                    state     <= SEND;
                    word_idx  <= '0;
                    bit_idx   <= '0;
                    len       <= len_c;
                    rem       <= rem_c;
                    FRAME_CNT <= frame_num;
                end
            end else begin
                BUSY        <= 1'b1;
                FRAME_START <= (word_idx == '0) && (bit_idx == 4'd0);
                MKD_TX      <= (word_idx == '0) && (bit_idx < 4'd4);
                if (bit_idx == 4'd0) begin
                    DATA_TX <= {word1[15], word0[15]};
                    sh0     <= {word0[14:0], 1'b0};
                    sh1     <= {word1[14:0], 1'b0};
                end else begin
                    DATA_TX <= {sh1[15], sh0[15]};
                    sh0     <= {sh0[14:0], 1'b0};
                    sh1     <= {sh1[14:0], 1'b0};
                end
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd15) begin
                    if (word_idx == WW'(FRAME_LEN - 1)) begin
                        // Last bit: chain straight into the next frame or go idle.
                        frame_num <= frame_num + 32'd1;
                        if (ENABLE) begin
                            word_idx  <= '0;
                            len       <= len_c;
                            rem       <= rem_c;
                            FRAME_CNT <= frame_num + 32'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        word_idx <= word_idx + WW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_m26_tx_core.sv
// Directed bench for m26_tx_core: captures whole frames and compares them word by word
// against frames built from the written hit words.
module tb_m26_tx_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        hit_wr;
    logic [15:0] hit_data;
    logic        full;
    logic [7:0]  lost_cnt;
    logic [31:0] frame_cnt;
    logic        busy;
    logic        frame_start;
    logic        mkd_tx;
    logic [1:0]  data_tx;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mkd_hi;
    int          busy_lo;
    int          start_cyc;
    logic [15:0] got0 [16];
    logic [15:0] got1 [16];
    logic [15:0] exp0 [16];
    logic [15:0] exp1 [16];
    logic [15:0] exp_data [$];
    bit          ok;
    bit          ok2;

    m26_tx_core #(.FRAME_LEN(16), .FIFO_AW(3)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(enable), .HIT_WR(hit_wr), .HIT_DATA(hit_data),
        .FULL(full), .LOST_CNT(lost_cnt), .FRAME_CNT(frame_cnt), .BUSY(busy),
        .FRAME_START(frame_start), .MKD_TX(mkd_tx), .DATA_TX(data_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_words(input int dly, input logic [15:0] base, input int n);
        repeat (dly) tick();
        for (int i = 0; i < n; i++) begin
            hit_data = base + 16'(i);
            hit_wr   = 1'b1;
            tick();
        end
        hit_wr = 1'b0;
    endtask

    // Waits (bounded) for FRAME_START, then records 16 words per lane plus MKD/BUSY.
    task automatic grab_frame(output bit found);
        int n = 0;
        while (!frame_start && n < 2000) begin
            tick();
            n++;
        end
        check("frame_start_seen", frame_start, 1);
        found = frame_start;
        if (!found) return;
        start_cyc = cyc;
        mkd_hi    = 0;
        busy_lo   = 0;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 16; b++) begin
                got0[w] = {got0[w][14:0], data_tx[0]};
                got1[w] = {got1[w][14:0], data_tx[1]};
                if (mkd_tx) mkd_hi++;
                if (!busy) busy_lo++;
                tick();
            end
        end
    endtask

    task automatic build_exp(input logic [31:0] fn, input int l);
        for (int w = 0; w < 16; w++) begin
            exp0[w] = 16'h0000;
            exp1[w] = 16'h0000;
        end
        exp0[0] = 16'h5555;     exp1[0] = 16'h5555;
        exp0[1] = fn[31:16];    exp1[1] = fn[15:0];
        exp0[2] = 16'(l);       exp1[2] = 16'(l);
        exp0[3] = 16'(l);       exp1[3] = 16'(l);
        for (int i = 0; i < l; i++) begin
            exp0[4+i] = exp_data[2*i];
            exp1[4+i] = (2*i + 1 < exp_data.size()) ? exp_data[2*i+1] : 16'h0000;
        end
        exp0[4+l] = 16'hAA50;   exp1[4+l] = 16'hAA50;
    endtask

    task automatic check_frame(input string name);
        for (int w = 0; w < 16; w++) begin
            check($sformatf("%s_lane0_w%0d", name, w), got0[w], exp0[w]);
            check($sformatf("%s_lane1_w%0d", name, w), got1[w], exp1[w]);
        end
        check({name, "_mkd_cycles"}, mkd_hi, 4);
        check({name, "_busy_gaps"}, busy_lo, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; hit_wr = 1'b0; hit_data = '0;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_mkd", mkd_tx, 0);
        check("rst_data", data_tx, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        check("rst_full", full, 0);

        // Three words, one frame, with start latency checked
        write_words(0, 16'h1111, 0);
        hit_data = 16'h1111; hit_wr = 1'b1; tick();
        hit_data = 16'h2222; tick();
        hit_data = 16'h3333; tick();
        hit_wr = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("lat_busy_k", busy, 0);
        check("lat_start_k", frame_start, 0);
        tick();
        check("lat_start_k1", frame_start, 1);
        check("lat_busy_k1", busy, 1);
        check("lat_mkd_k1", mkd_tx, 1);
        exp_data = '{16'h1111, 16'h2222, 16'h3333};
        grab_frame(ok);
        if (ok) begin
            build_exp(32'd0, 2);
            check_frame("f3w");
        end
        check("f3w_busy_after", busy, 0);
        check("f3w_frame_cnt", frame_cnt, 0);

        // Back-to-back frames from an empty FIFO
        do_reset();
        exp_data.delete();
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int prev;
            prev = start_cyc;
            grab_frame(ok);
            if (f == 1) enable = 1'b0;
            if (ok) begin
                build_exp(32'(f), 0);
                check_frame($sformatf("b2b%0d", f));
                if (f > 0) check($sformatf("b2b%0d_spacing", f), start_cyc - prev, 256);
            end
        end
        check("b2b_busy_after", busy, 0);
        check("b2b_frame_cnt", frame_cnt, 2);

        // Overfill a depth-8 FIFO, then drain it in one frame
        do_reset();
        for (int i = 0; i < 10; i++) begin
            hit_data = 16'hA000 + 16'(i);
            hit_wr   = 1'b1;
            tick();
            if (i == 6) check("ovf_full_at7", full, 0);
            if (i == 7) check("ovf_full_at8", full, 1);
        end
        hit_wr = 1'b0;
        check("ovf_lost", lost_cnt, 2);
        exp_data = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                     16'hA004, 16'hA005, 16'hA006, 16'hA007};
        enable = 1'b1; tick(); enable = 1'b0;
        grab_frame(ok);
        if (ok) begin
            build_exp(32'd0, 4);
            check_frame("ovf");
        end
        check("ovf_full_after", full, 0);
        exp_data.delete();
        enable = 1'b1; tick(); enable = 1'b0;
        grab_frame(ok);
        if (ok) begin
            build_exp(32'd1, 0);
            check_frame("ovf_drained");
        end
        check("ovf_lost_kept", lost_cnt, 2);

        // Words written during frame 0 go to frame 1
        do_reset();
        enable = 1'b1;
        fork
            grab_frame(ok);
            write_words(20, 16'hB000, 3);
        join
        exp_data.delete();
        if (ok) begin
            build_exp(32'd0, 0);
            check_frame("mid0");
        end
        grab_frame(ok);
        enable = 1'b0;
        exp_data = '{16'hB000, 16'hB001, 16'hB002};
        if (ok) begin
            build_exp(32'd1, 2);
            check_frame("mid1");
        end

        // Reset at cycle 40 of frame 1 aborts it and restarts numbering
        do_reset();
        enable = 1'b1;
        fork
            grab_frame(ok2);
            write_words(20, 16'hC000, 2);
        join
        enable = 1'b0;
        check("rstmid_frame1_start", frame_start, 1);
        check("rstmid_frame_cnt_before", frame_cnt, 1);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check("rstmid_busy", busy, 0);
        check("rstmid_mkd", mkd_tx, 0);
        check("rstmid_data", data_tx, 0);
        check("rstmid_start", frame_start, 0);
        check("rstmid_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        exp_data.delete();
        enable = 1'b1; tick(); enable = 1'b0;
        grab_frame(ok);
        if (ok) begin
            build_exp(32'd0, 0);
            check_frame("after_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
